// File: rtl/stepper_move_ctrl.sv
// stepper_move_ctrl: single-axis stepper move controller.
// Takes a go/done request from the move sequencer and steps a 4-wire coil
// pattern forward or backward, in full or half steps, with a trapezoidal
// speed ramp. Limit switches end the move early.
module stepper_move_ctrl #(
  parameter int STEP_W       = 12,
  parameter int DIV_W        = 24,
  parameter int PERIOD       = 50000,
  parameter int START_PERIOD = 200000,
  parameter int RAMP_STEP    = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              go,
  input  logic              dir,
  input  logic              half_step,
  input  logic [STEP_W-1:0] steps,
  input  logic [3:0]        old_state,
  input  logic              boundary_fwd,
  input  logic              boundary_bwd,
  output logic [3:0]        state,
  output logic              busy,
  output logic              done,
  output logic              hit_boundary,
  output logic [STEP_W-1:0] steps_done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  localparam logic [3:0] PHASES [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                                        4'b0010, 4'b0011, 4'b0001, 4'b1001};

  // Period arithmetic is one bit wider so ramp sums never wrap.
  localparam logic [DIV_W:0] PERIOD_X = (DIV_W+1)'(PERIOD);
  localparam logic [DIV_W:0] START_X  = (DIV_W+1)'(START_PERIOD);
  localparam logic [DIV_W:0] RAMP_X   = (DIV_W+1)'(RAMP_STEP);

  fsm_t              fsm;
  logic [2:0]        phase_idx;
  logic [STEP_W-1:0] steps_lat;
  logic [STEP_W-1:0] ramp_cnt;
  logic              dir_lat;
  logic              half_lat;
  logic [DIV_W-1:0]  period;
  logic [DIV_W-1:0]  counter;

  // Patterns outside the phase table resume from 1100.
  function automatic logic [2:0] pattern_to_idx(input logic [3:0] p);
    case (p)
      4'b1000: return 3'd0;
      4'b1100: return 3'd1;
      4'b0100: return 3'd2;
      4'b0110: return 3'd3;
      4'b0010: return 3'd4;
      4'b0011: return 3'd5;
      4'b0001: return 3'd6;
      4'b1001: return 3'd7;
      default: return 3'd1;
    endcase
  endfunction

  logic [2:0]        stride;
  logic [2:0]        next_idx;
  logic [2:0]        old_idx;
  logic [STEP_W-1:0] done_next;
  logic [STEP_W-1:0] rem;
  logic [DIV_W:0]    per_up;
  logic [DIV_W:0]    per_dn;
  logic              step_due;
  logic              run_bnd;
  logic              start_bnd;

  // Next phase, ramped period candidates and limit-switch selection for the current cycle.
  always_comb begin
    stride    = half_lat ? 3'd1 : 3'd2;
    next_idx  = dir_lat ? phase_idx + stride : phase_idx - stride;
    old_idx   = pattern_to_idx(old_state);
    done_next = steps_done + STEP_W'(1);
    rem       = steps_lat - done_next;
    per_up    = ({1'b0, period} + RAMP_X > START_X) ? START_X : {1'b0, period} + RAMP_X;
    per_dn    = ({1'b0, period} > PERIOD_X + RAMP_X) ? {1'b0, period} - RAMP_X : PERIOD_X;
    step_due  = (counter == period - DIV_W'(1));
    run_bnd   = dir_lat ? boundary_fwd : boundary_bwd;
    start_bnd = dir ? boundary_fwd : boundary_bwd;
  end

  // Move FSM with registered coil pattern, status flags and ramp counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm          <= IDLE;
      phase_idx    <= 3'd1;
      state        <= 4'b1100;
      busy         <= 1'b0;
      done         <= 1'b0;
      hit_boundary <= 1'b0;
      steps_done   <= '0;
      steps_lat    <= '0;
      ramp_cnt     <= '0;
      dir_lat      <= 1'b0;
      half_lat     <= 1'b0;
      period       <= '0;
      counter      <= '0;
    end else begin
      done <= (fsm == DONE);
      case (fsm)
        IDLE: begin
          phase_idx <= old_idx;
          state     <= PHASES[old_idx];
          if (go) begin
            steps_lat    <= steps;
            dir_lat      <= dir;
            half_lat     <= half_step;
            period       <= DIV_W'(START_PERIOD);
            counter      <= '0;
            ramp_cnt     <= '0;
            steps_done   <= '0;
            hit_boundary <= start_bnd;
            if (steps == '0 || start_bnd) begin
              fsm  <= DONE;
              busy <= 1'b0;
            end else begin
              fsm  <= RUN;
              busy <= 1'b1;
            end
          end
        end
        RUN: begin
          if (!go) begin
            fsm  <= IDLE;
            busy <= 1'b0;
          end else if (run_bnd) begin
            fsm          <= DONE;
            busy         <= 1'b0;
            hit_boundary <= 1'b1;
          end else if (step_due) begin
            phase_idx  <= next_idx;
            state      <= PHASES[next_idx];
            steps_done <= done_next;
            counter    <= '0;
            if (rem <= ramp_cnt) begin
              period <= per_up[DIV_W-1:0];
              if (ramp_cnt != '0) ramp_cnt <= ramp_cnt - STEP_W'(1);
            end else if ({1'b0, period} > PERIOD_X) begin
              period   <= per_dn[DIV_W-1:0];
              ramp_cnt <= ramp_cnt + STEP_W'(1);
            end
            if (done_next == steps_lat) begin
              fsm  <= DONE;
              busy <= 1'b0;
            end
          end else begin
            counter <= counter + DIV_W'(1);
          end
        end
        DONE: begin
          if (!go) fsm <= IDLE;
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stepper_move_ctrl.sv
// tb_stepper_move_ctrl: drives two controllers in parallel, one without ramp
// (PERIOD=4, START_PERIOD=4) and one with ramp (START_PERIOD=10, RAMP_STEP=2),
// and compares both against a step-schedule model every cycle.
module tb_stepper_move_ctrl;

  logic        clk = 1'b0;
  logic        reset, go, dir, half_step, boundary_fwd, boundary_bwd;
  logic [11:0] steps;
  logic [3:0]  old_state;
  logic [3:0]  st_a, st_r;
  logic        busy_a, busy_r, done_a, done_r, hit_a, hit_r;
  logic [11:0] sd_a, sd_r;
  int          n_checks = 0;
  int          n_pass = 0;

  localparam logic [3:0] TBL [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                                     4'b0010, 4'b0011, 4'b0001, 4'b1001};

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  stepper_move_ctrl #(.STEP_W(12), .DIV_W(24), .PERIOD(4), .START_PERIOD(4), .RAMP_STEP(1)) dut_a (
    .clk(clk), .reset(reset), .go(go), .dir(dir), .half_step(half_step), .steps(steps),
    .old_state(old_state), .boundary_fwd(boundary_fwd), .boundary_bwd(boundary_bwd),
    .state(st_a), .busy(busy_a), .done(done_a), .hit_boundary(hit_a), .steps_done(sd_a));

  stepper_move_ctrl #(.STEP_W(12), .DIV_W(24), .PERIOD(4), .START_PERIOD(10), .RAMP_STEP(2)) dut_r (
    .clk(clk), .reset(reset), .go(go), .dir(dir), .half_step(half_step), .steps(steps),
    .old_state(old_state), .boundary_fwd(boundary_fwd), .boundary_bwd(boundary_bwd),
    .state(st_r), .busy(busy_r), .done(done_r), .hit_boundary(hit_r), .steps_done(sd_r));

  // Global time limit so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Packed view {state, busy, done, hit_boundary, steps_done} of instance x.
  function automatic logic [18:0] obs(input int x);
    return (x == 0) ? {st_a, busy_a, done_a, hit_a, sd_a} : {st_r, busy_r, done_r, hit_r, sd_r};
  endfunction

  function automatic int lookup(input logic [3:0] p);
    for (int i = 0; i < 8; i++) if (TBL[i] == p) return i;
    return 1;
  endfunction

  // Cycles spent on step k of an n-step move, from the ramp rules.
  function automatic int spacing(input int x, input int n, input int k);
    int sp = (x == 0) ? 4 : 10;
    int rs = (x == 0) ? 1 : 2;
    int p  = sp;
    int rc = 0;
    for (int i = 1; i < k; i++) begin
      if (n - i <= rc) begin
        p = (p + rs > sp) ? sp : p + rs;
        if (rc > 0) rc--;
      end else if (p > 4) begin
        p = (p - rs < 4) ? 4 : p - rs;
        rc++;
      end
    end
    return p;
  endfunction

  function automatic int cum(input int x, input int n, input int k);
    int t = 0;
    for (int i = 1; i <= k; i++) t += spacing(x, n, i);
    return t;
  endfunction

  function automatic int steps_by(input int x, input int n, input int c);
    int cnt = 0;
    for (int k = 1; k <= n; k++) if (cum(x, n, k) <= c) cnt++;
    return cnt;
  endfunction

  function automatic logic [3:0] expect_pat(input int start, input bit d, input bit h, input int cnt);
    int v = start + (d ? 1 : -1) * (h ? 1 : 2) * cnt;
    v = ((v % 8) + 8) % 8;
    return TBL[v];
  endfunction

  // Complete move followed by release; checks every cycle on both instances.
  task automatic run_move(input string name, input bit d, input bit h, input int n, input logic [3:0] old);
    int start = lookup(old);
    int tot [2];
    int tmax;
    logic [18:0] exp_v;
    dir = d; half_step = h; steps = 12'(n); old_state = old;
    boundary_fwd = 1'b0; boundary_bwd = 1'b0; go = 1'b1;
    for (int x = 0; x < 2; x++) tot[x] = (n == 0) ? 0 : cum(x, n, n);
    tmax = ((tot[0] > tot[1]) ? tot[0] : tot[1]) + 2;
    for (int c = 0; c <= tmax; c++) begin
      tick();
      for (int x = 0; x < 2; x++) begin
        int cnt = steps_by(x, n, c);
        exp_v = {expect_pat(start, d, h, cnt), (n != 0 && c < tot[x]), (c >= tot[x] + 1), 1'b0, 12'(cnt)};
        n_checks++;
        if (obs(x) !== exp_v)
          $display("[TB] FAIL %s dut%0d cycle %0d: got %h expected %h", name, x, c, obs(x), exp_v);
        else n_pass++;
      end
    end
    go = 1'b0;
    tick();
    for (int x = 0; x < 2; x++) begin
      exp_v = {expect_pat(start, d, h, n), 1'b0, 1'b1, 1'b0, 12'(n)};
      n_checks++;
      if (obs(x) !== exp_v) $display("[TB] FAIL %s_release dut%0d: got %h expected %h", name, x, obs(x), exp_v);
      else n_pass++;
    end
    tick();
    for (int x = 0; x < 2; x++) begin
      exp_v = {TBL[start], 1'b0, 1'b0, 1'b0, 12'(n)};
      n_checks++;
      if (obs(x) !== exp_v) $display("[TB] FAIL %s_idle dut%0d: got %h expected %h", name, x, obs(x), exp_v);
      else n_pass++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; go = 1'b0; dir = 1'b0; half_step = 1'b0; steps = '0;
    old_state = 4'b0011; boundary_fwd = 1'b0; boundary_bwd = 1'b0;
    tick(); tick();
    for (int x = 0; x < 2; x++) begin
      n_checks++;
      if (obs(x) !== {4'b1100, 3'b000, 12'd0}) $display("[TB] FAIL reset dut%0d: got %h expected %h", x, obs(x), {4'b1100, 3'b000, 12'd0});
      else n_pass++;
    end
    reset = 1'b0;
    tick();
    n_checks++;
    if (st_a !== 4'b0011) $display("[TB] FAIL idle_reload: got %b expected 0011", st_a);
    else n_pass++;
  endtask

  task automatic test_full_fwd;
    run_move("full_fwd", 1'b1, 1'b0, 3, 4'b1100);
  endtask

  task automatic test_half_bwd;
    run_move("half_bwd", 1'b0, 1'b1, 3, 4'b1100);
  endtask

  task automatic test_ramp;
    run_move("ramp", 1'b1, 1'b0, 8, 4'b1100);
  endtask

  task automatic test_zero_steps;
    run_move("zero_steps", 1'b1, 1'b1, 0, 4'b0110);
  endtask

  // Forward limit sampled at edge b of the move; the backward switch is held high and must be ignored.
  task automatic test_boundary(input int b);
    logic [18:0] exp_v;
    dir = 1'b1; half_step = 1'b0; steps = 12'd6; old_state = 4'b1100;
    boundary_fwd = 1'b0; boundary_bwd = 1'b1; go = 1'b1;
    for (int c = 0; c <= b + 2; c++) begin
      tick();
      for (int x = 0; x < 2; x++) begin
        int cnt = (c < b) ? steps_by(x, 6, c) : steps_by(x, 6, b - 1);
        exp_v = {expect_pat(1, 1'b1, 1'b0, cnt), (c < b), (c >= b + 1), (c >= b), 12'(cnt)};
        n_checks++;
        if (obs(x) !== exp_v)
          $display("[TB] FAIL boundary_b%0d dut%0d cycle %0d: got %h expected %h", b, x, c, obs(x), exp_v);
        else n_pass++;
      end
      if (c == b - 1) boundary_fwd = 1'b1;
    end
    go = 1'b0; boundary_fwd = 1'b0; boundary_bwd = 1'b0;
    tick(); tick();
    for (int x = 0; x < 2; x++) begin
      n_checks++;
      if ({done_a, hit_a, done_r, hit_r} !== 4'b0101)
        $display("[TB] FAIL boundary_release dut%0d: got %b expected 0101", x, {done_a, hit_a, done_r, hit_r});
      else n_pass++;
    end
  endtask

  task automatic test_boundary_start;
    logic [18:0] exp_v;
    dir = 1'b0; half_step = 1'b0; steps = 12'd5; old_state = 4'b0110;
    boundary_fwd = 1'b0; boundary_bwd = 1'b1; go = 1'b1;
    for (int c = 0; c <= 2; c++) begin
      tick();
      for (int x = 0; x < 2; x++) begin
        exp_v = {4'b0110, 1'b0, (c >= 1), 1'b1, 12'd0};
        n_checks++;
        if (obs(x) !== exp_v) $display("[TB] FAIL boundary_start dut%0d cycle %0d: got %h expected %h", x, c, obs(x), exp_v);
        else n_pass++;
      end
    end
    go = 1'b0; boundary_bwd = 1'b0;
    tick(); tick();
  endtask

  // go dropped after the first step of the unramped instance.
  task automatic test_abort;
    logic [18:0] exp_v;
    logic [3:0]  follow;
    dir = 1'b1; half_step = 1'b0; steps = 12'd5; old_state = 4'b1100;
    boundary_fwd = 1'b0; boundary_bwd = 1'b0; go = 1'b1;
    for (int c = 0; c <= 8; c++) begin
      tick();
      for (int x = 0; x < 2; x++) begin
        int cnt = steps_by(x, 5, (c < 5) ? c : 4);
        follow = (c == 6) ? 4'b0011 : 4'b1001;
        exp_v = {(c < 6) ? expect_pat(1, 1'b1, 1'b0, cnt) : follow, (c < 5), 1'b0, 1'b0, 12'(cnt)};
        n_checks++;
        if (obs(x) !== exp_v) $display("[TB] FAIL abort dut%0d cycle %0d: got %h expected %h", x, c, obs(x), exp_v);
        else n_pass++;
      end
      if (c == 4) begin go = 1'b0; old_state = 4'b0011; end
      if (c == 6) old_state = 4'b1001;
    end
  endtask

  task automatic test_reset_mid;
    dir = 1'b1; half_step = 1'b0; steps = 12'd5; old_state = 4'b1100; go = 1'b1;
    for (int c = 0; c <= 6; c++) tick();
    reset = 1'b1; go = 1'b0; old_state = 4'b0110;
    tick();
    for (int x = 0; x < 2; x++) begin
      n_checks++;
      if (obs(x) !== {4'b1100, 3'b000, 12'd0}) $display("[TB] FAIL reset_mid dut%0d: got %h expected %h", x, obs(x), {4'b1100, 3'b000, 12'd0});
      else n_pass++;
    end
    reset = 1'b0;
    tick();
    run_move("after_reset", 1'b0, 1'b1, 2, 4'b1001);
  endtask

  task automatic test_random;
    for (int i = 0; i < 10; i++) begin
      run_move("random", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               int'($urandom_range(0, 6)), 4'($urandom_range(0, 15)));
    end
  endtask

  // Scenario sequence and summary.
  initial begin
    test_reset();
    test_full_fwd();
    test_half_bwd();
    test_ramp();
    test_zero_steps();
    test_boundary(9);
    test_boundary(12);
    test_boundary_start();
    test_abort();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
